// File: rtl/fifo_chan_adapt_pkg.sv
// Shared types and elaboration helpers for the channel-adapting inter-layer FIFO.
package fifo_chan_adapt_pkg;

  typedef enum logic [1:0] {PASS, NARROW, WIDEN} adapt_mode_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Integer ratio of the larger to the smaller channel count; 1 when a <= b.
  function automatic int ratio(input int a, input int b);
    return (a > b) ? a / b : 1;
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic adapt_mode_e sel_mode(input int wr_ch, input int rd_ch);
    if (wr_ch > rd_ch) return NARROW;
    if (rd_ch > wr_ch) return WIDEN;
    return PASS;
  endfunction

endpackage

// File: rtl/fifo_chan_adapt_mem.sv
// Simple dual-port entry storage: synchronous write, combinational first-word-fall-through read.
module fifo_chan_adapt_mem #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8,
  parameter int unsigned PtrW  = 3
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [PtrW-1:0]  waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [PtrW-1:0]  raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Block-RAM mapping would register this read as a prefetch stage ahead of the head.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_chan_adapt.sv
// Inter-layer activation FIFO with pack/unpack between WR_CH and RD_CH channel beats.
// Define FIFO_ERR_CHECK_EN to add sticky overflow/underflow outputs.
module fifo_chan_adapt
  import fifo_chan_adapt_pkg::*;
#(
  parameter int CH_BITS           = 8,
  parameter int WR_CH             = 16,
  parameter int RD_CH             = 4,
  parameter int DEPTH             = 64,
  parameter int ALMOST_FULL_THRES = 48
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WR_CH*CH_BITS-1:0]   wr_data,
  input  logic                       wr_en,
  input  logic                       rd_en,
  output logic [RD_CH*CH_BITS-1:0]   rd_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FIFO_ERR_CHECK_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int WW = WR_CH * CH_BITS;
  localparam int RW = RD_CH * CH_BITS;
  localparam int MW = max_int(WR_CH, RD_CH) * CH_BITS;
  localparam int R  = ratio(WR_CH, RD_CH);
  localparam int P  = ratio(RD_CH, WR_CH);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam int SW = ptr_w(max_int(R, P));
  localparam adapt_mode_e Mode = sel_mode(WR_CH, RD_CH);

  localparam logic [SW-1:0] IdxLast = SW'(max_int(R, P) - 1);
  localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

  if ((WR_CH % RD_CH != 0) && (RD_CH % WR_CH != 0)) begin : g_bad_ratio
    $error("fifo_chan_adapt: WR_CH and RD_CH must divide one another");
  end
  if ((ALMOST_FULL_THRES < 1) || (ALMOST_FULL_THRES > DEPTH)) begin : g_bad_thres
    $error("fifo_chan_adapt: ALMOST_FULL_THRES must lie in 1..DEPTH");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  // Read slice index when narrowing, write pack index when widening.
  logic [SW-1:0] idx_q, idx_d, rd_slice;
  logic [MW-1:0] pack_q, pack_d, commit_data, head;
  logic          empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic          wr_acc, rd_acc, commit, free;

  always_comb begin
    wr_acc      = wr_en & ~full_q;
    rd_acc      = rd_en & ~empty_q;
    idx_d       = idx_q;
    pack_d      = pack_q;
    commit      = 1'b0;
    free        = 1'b0;
    commit_data = '0;
    rd_slice    = '0;
    case (Mode)
      NARROW: begin
        commit      = wr_acc;
        commit_data = MW'(wr_data);
        free        = rd_acc & (idx_q == IdxLast);
        rd_slice    = idx_q;
        if (rd_acc) begin
          idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
        end
      end
      WIDEN: begin
        free = rd_acc;
        if (wr_acc) begin
          pack_d[int'(idx_q)*WW +: WW] = wr_data;
          if (idx_q == IdxLast) begin
            commit      = 1'b1;
            commit_data = pack_d;
            idx_d       = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        commit      = wr_acc;
        commit_data = MW'(wr_data);
        free        = rd_acc;
      end
    endcase

    wr_ptr_d = wr_ptr_q;
    if (commit) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    rd_ptr_d = rd_ptr_q;
    if (free) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(commit) - CW'(free);
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
    af_d    = (count_d >= CW'(ALMOST_FULL_THRES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      pack_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      af_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      pack_q   <= pack_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      af_q     <= af_d;
    end
  end

  fifo_chan_adapt_mem #(
    .Width (MW),
    .Depth (DEPTH),
    .PtrW  (PW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (commit),
    .waddr_i (wr_ptr_q),
    .wdata_i (commit_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign rd_data     = head[int'(rd_slice)*RW +: RW];
  assign empty       = empty_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign count       = count_q;

`ifdef FIFO_ERR_CHECK_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en & full_q);
    udf_d = udf_q | (rd_en & empty_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_fifo_chan_adapt.sv
// Bench for fifo_chan_adapt: four configurations checked against a channel-queue model.
module tb_fifo_chan_adapt;

  logic         clk;
  logic         rst;
  logic [127:0] wr_data_a [4];
  logic         wr_en_a   [4];
  logic         rd_en_a   [4];

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 0: narrow 16->4, 1: widen 4->16, 2: plain depth 8 thres 6, 3: plain depth 6
  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int Wc = (g == 0) ? 16 : 4;
    localparam int Rc = (g == 1) ? 16 : 4;
    localparam int Dc = (g == 2) ? 8 : (g == 3) ? 6 : 64;
    localparam int Tc = (g >= 2) ? 6 : 48;
    localparam int R  = (Wc >= Rc) ? Wc / Rc : 1;
    localparam int P  = (Rc > Wc) ? Rc / Wc : 1;
    localparam logic [127:0] RMask = {128{1'b1}} >> (128 - Rc * 8);
    localparam logic [127:0] WMask = {128{1'b1}} >> (128 - Wc * 8);

    logic [Rc*8-1:0]          rd_data;
    logic                     empty, full, almost_full;
    logic [$clog2(Dc+1)-1:0]  count;
`ifdef FIFO_ERR_CHECK_EN
    logic                     ovf, udf;
`endif

    fifo_chan_adapt #(
      .CH_BITS           (8),
      .WR_CH             (Wc),
      .RD_CH             (Rc),
      .DEPTH             (Dc),
      .ALMOST_FULL_THRES (Tc)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .wr_data     (wr_data_a[g][Wc*8-1:0]),
      .wr_en       (wr_en_a[g]),
      .rd_en       (rd_en_a[g]),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .almost_full (almost_full),
      .count       (count)
`ifdef FIFO_ERR_CHECK_EN
      ,
      .overflow    (ovf),
      .underflow   (udf)
`endif
    );

    // Model: queue of pending read beats plus partially gathered write beats.
    logic [127:0] beats [$];
    logic [127:0] pack;
    int           npack;
    bit           m_ovf, m_udf;

    function automatic int m_cnt();
      return (beats.size() + R - 1) / R;
    endfunction

    always @(posedge clk or posedge rst) begin : model
      bit was_full, was_empty;
      if (rst) begin
        beats.delete();
        pack  = '0;
        npack = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        was_full  = (m_cnt() == Dc);
        was_empty = (beats.size() == 0);
        if (rd_en_a[g]) begin
          if (was_empty) m_udf = 1'b1;
          else void'(beats.pop_front());
        end
        if (wr_en_a[g]) begin
          if (was_full) begin
            m_ovf = 1'b1;
          end else if (P == 1) begin
            for (int s = 0; s < R; s++) beats.push_back((wr_data_a[g] >> (s * Rc * 8)) & RMask);
          end else begin
            pack = pack | ((wr_data_a[g] & WMask) << (npack * Wc * 8));
            npack++;
            if (npack == P) begin
              beats.push_back(pack);
              pack  = '0;
              npack = 0;
            end
          end
        end
      end
    end

    always @(negedge clk) begin : compare
      if (!rst) begin
        check($sformatf("g%0d.empty", g), empty, beats.size() == 0);
        check($sformatf("g%0d.full", g), full, m_cnt() == Dc);
        check($sformatf("g%0d.almost_full", g), almost_full, m_cnt() >= Tc);
        check($sformatf("g%0d.count", g), count, m_cnt());
        if (beats.size() != 0) check($sformatf("g%0d.rd_data", g), rd_data, beats[0] & RMask);
`ifdef FIFO_ERR_CHECK_EN
        check($sformatf("g%0d.overflow", g), ovf, m_ovf);
        check($sformatf("g%0d.underflow", g), udf, m_udf);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  ne [4];
    logic [31:0]  wb [4];
    logic [127:0] full_word, rev_word;
    int           c, seq;

    ne[0] = 32'h03020100; ne[1] = 32'h07060504; ne[2] = 32'h0B0A0908; ne[3] = 32'h0F0E0D0C;
    wb = ne;
    full_word = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    rev_word  = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
    for (int i = 0; i < 4; i++) begin
      wr_data_a[i] = '0;
      wr_en_a[i]   = 1'b0;
      rd_en_a[i]   = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_empty", g_inst[0].empty, 1);
    check("rst_full", g_inst[0].full, 0);
    check("rst_af", g_inst[2].almost_full, 0);
    check("rst_count", g_inst[2].count, 0);
    rst = 1'b0;

    // Narrowing: one 16-channel beat read as four 4-channel slices.
    @(negedge clk);
    wr_data_a[0] = full_word;
    wr_en_a[0]   = 1'b1;
    @(negedge clk);
    wr_en_a[0] = 1'b0;
    check("nar_empty_next", g_inst[0].empty, 0);
    for (int i = 0; i < 4; i++) begin
      check("nar_slice", g_inst[0].rd_data, ne[i]);
      check("nar_count_held", g_inst[0].count, 1);
      rd_en_a[0] = 1'b1;
      @(negedge clk);
    end
    rd_en_a[0] = 1'b0;
    check("nar_count_done", g_inst[0].count, 0);
    check("nar_empty_done", g_inst[0].empty, 1);

    // Widening: four 4-channel beats packed into one 16-channel word.
    for (int j = 0; j < 4; j++) begin
      wr_data_a[1] = 128'(wb[j]);
      wr_en_a[1]   = 1'b1;
      @(negedge clk);
      if (j < 3) check("wid_partial_empty", g_inst[1].empty, 1);
    end
    wr_en_a[1] = 1'b0;
    check("wid_empty", g_inst[1].empty, 0);
    check("wid_count", g_inst[1].count, 1);
    check("wid_word", g_inst[1].rd_data, full_word);
    rd_en_a[1] = 1'b1;
    @(negedge clk);
    rd_en_a[1] = 1'b0;
    check("wid_popped", g_inst[1].empty, 1);
    for (int j = 0; j < 3; j++) begin
      wr_data_a[1] = 128'(wb[j]);
      wr_en_a[1]   = 1'b1;
      @(negedge clk);
    end
    wr_en_a[1] = 1'b0;
    rst = 1'b1;
    #1;
    check("wid_rst_empty", g_inst[1].empty, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      wr_data_a[1] = 128'(wb[3-j]);
      wr_en_a[1]   = 1'b1;
      @(negedge clk);
      if (j < 3) check("wid_rst_pack_cleared", g_inst[1].empty, 1);
    end
    wr_en_a[1] = 1'b0;
    check("wid_word_rev", g_inst[1].rd_data, rev_word);
    rd_en_a[1] = 1'b1;
    @(negedge clk);
    rd_en_a[1] = 1'b0;

    // Plain depth 8: thresholds, full, dropped write alongside a pop.
    for (int j = 1; j <= 8; j++) begin
      wr_data_a[2] = 128'(j);
      wr_en_a[2]   = 1'b1;
      @(negedge clk);
      check("p8_af", g_inst[2].almost_full, j >= 6);
      check("p8_full", g_inst[2].full, j == 8);
      check("p8_count", g_inst[2].count, j);
    end
    wr_data_a[2] = 128'd9;
    rd_en_a[2]   = 1'b1;
    @(negedge clk);
    wr_en_a[2] = 1'b0;
    rd_en_a[2] = 1'b0;
    check("p8_drop_count", g_inst[2].count, 7);
    check("p8_drop_full", g_inst[2].full, 0);
    check("p8_drop_head", g_inst[2].rd_data, 2);
`ifdef FIFO_ERR_CHECK_EN
    check("p8_overflow", g_inst[2].ovf, 1);
`endif
    for (int j = 2; j <= 8; j++) begin
      check("p8_drain", g_inst[2].rd_data, j);
      rd_en_a[2] = 1'b1;
      @(negedge clk);
    end
    check("p8_drained", g_inst[2].empty, 1);
    @(negedge clk);
    rd_en_a[2] = 1'b0;
    check("p8_underrun_count", g_inst[2].count, 0);
`ifdef FIFO_ERR_CHECK_EN
    check("p8_underflow", g_inst[2].udf, 1);
`endif
    wr_data_a[2] = 128'hAB;
    wr_en_a[2]   = 1'b1;
    @(negedge clk);
    wr_en_a[2] = 1'b0;
    check("p8_after_underrun", g_inst[2].rd_data, 8'hAB);
    check("p8_after_count", g_inst[2].count, 1);
`ifdef FIFO_ERR_CHECK_EN
    check("p8_underflow_sticky", g_inst[2].udf, 1);
`endif
    rd_en_a[2] = 1'b1;
    @(negedge clk);
    rd_en_a[2] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      wr_data_a[2] = 128'(8'h10 + j);
      wr_en_a[2]   = 1'b1;
      @(negedge clk);
    end
    wr_en_a[2] = 1'b0;
    check("p8_five", g_inst[2].count, 5);
    #2;
    rst = 1'b1;
    #1;
    check("async_count", g_inst[2].count, 0);
    check("async_empty", g_inst[2].empty, 1);
    check("async_full", g_inst[2].full, 0);
    check("async_af", g_inst[2].almost_full, 0);
`ifdef FIFO_ERR_CHECK_EN
    check("async_ovf", g_inst[2].ovf, 0);
    check("async_udf", g_inst[2].udf, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Depth 6: random traffic held at 2..4 entries so both pointers wrap repeatedly.
    seq = 0;
    for (int j = 0; j < 3; j++) begin
      wr_data_a[3] = 128'(seq++);
      wr_en_a[3]   = 1'b1;
      @(negedge clk);
    end
    wr_en_a[3] = 1'b0;
    check("wrap_fill", g_inst[3].count, 3);
    for (int n = 0; n < 1000; n++) begin
      c = int'(g_inst[3].count);
      wr_en_a[3]   = (c < 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd_en_a[3]   = (c > 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_data_a[3] = 128'(seq);
      if (wr_en_a[3]) seq++;
      @(negedge clk);
    end
    wr_en_a[3] = 1'b0;
    rd_en_a[3] = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
